// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides and a registered ALUResult/Zero.
// Shifts step one bit per cycle unless FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_LUI = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_LT  = 4'b1100;
  localparam logic [3:0] OP_GE  = 4'b1111;

`ifdef FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  function automatic logic [DATA_WIDTH-1:0] f_alu(input logic [3:0] op,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    case (op)
      OP_AND:        res = a & b;
      OP_OR:         res = a | b;
      OP_ADD:        res = a + b;
      OP_SUB:        res = a - b;
      OP_XOR:        res = a ^ b;
      OP_SLT, OP_LT: res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LUI:        res = b;
      OP_EQ:         res = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
      OP_GE:         res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) >= $signed(b))};
      default:       res = '0;
    endcase
    return res;
  endfunction

  function automatic logic f_is_shift(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

`ifdef FAST_SHIFT_EN
  function automatic logic [DATA_WIDTH-1:0] f_barrel(input logic [3:0] op,
                                                     input logic [DATA_WIDTH-1:0] a,
                                                     input logic [SHAMT_W-1:0] sh);
    logic [DATA_WIDTH-1:0] res;
    case (op)
      OP_SLL:  res = a << sh;
      OP_SRA:  res = $signed(a) >>> sh;
      default: res = a >> sh;
    endcase
    return res;
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] f_step(input logic [3:0] op,
                                                   input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] res;
    case (op)
      OP_SLL:  res = {v[DATA_WIDTH-2:0], 1'b0};
      OP_SRA:  res = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      default: res = {1'b0, v[DATA_WIDTH-1:1]};
    endcase
    return res;
  endfunction
`endif

  state_t                r_state, w_next, w_start;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_is_shift;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_res;

`ifndef FAST_SHIFT_EN
  logic [DATA_WIDTH-1:0] r_work;
  logic [SHAMT_W-1:0]    r_cnt;
  logic [3:0]            r_shop;
  logic                  w_go_shift;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_step;
`endif

  assign w_shamt    = SrcB[SHAMT_W-1:0];
  assign w_is_shift = f_is_shift(Operation);
  assign InReady    = (r_state == IDLE) || ((r_state == DONE) && OutReady);
  assign OutValid   = (r_state == DONE);
  assign w_accept   = InValid && InReady;
  assign ALUResult  = r_result;
  assign Zero       = r_zero;

`ifdef FAST_SHIFT_EN
  assign w_res = w_is_shift ? f_barrel(Operation, SrcA, w_shamt) : f_alu(Operation, SrcA, SrcB);
`else
  // A zero-distance shift bypasses SHIFT and completes like any other op.
  assign w_go_shift = w_is_shift && (w_shamt != '0);
  assign w_res      = w_is_shift ? SrcA : f_alu(Operation, SrcA, SrcB);
  assign w_step     = f_step(r_shop, r_work);
  assign w_last     = (r_cnt == SHAMT_W'(1));
`endif

  always_comb begin
    w_next  = r_state;
    w_start = DONE;
`ifndef FAST_SHIFT_EN
    if (w_go_shift) w_start = SHIFT;
`endif
    case (r_state)
      IDLE: if (w_accept) w_next = w_start;
`ifndef FAST_SHIFT_EN
      SHIFT: if (w_last) w_next = DONE;
`endif
      DONE: if (OutReady) w_next = w_accept ? w_start : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Result/Zero only move when an op finishes, so they stay stable through backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
`ifndef FAST_SHIFT_EN
      r_work   <= '0;
      r_cnt    <= '0;
      r_shop   <= OP_SRL;
`endif
    end else if (w_accept) begin
`ifdef FAST_SHIFT_EN
      r_result <= w_res;
      r_zero   <= (w_res == '0);
`else
      if (w_go_shift) begin
        r_work <= SrcA;
        r_cnt  <= w_shamt;
        r_shop <= Operation;
      end else begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
      end
`endif
    end
`ifndef FAST_SHIFT_EN
    else if (r_state == SHIFT) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - SHAMT_W'(1);
      if (w_last) begin
        r_result <= w_step;
        r_zero   <= (w_step == '0);
      end
    end
`endif
  end

endmodule
